bit_iter: RTL

BIT_ITER -- requirements
Module: bit_iter

---
 rtl/bit_iter.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/bit_iter.sv
// ---------------------------------------------------------------------------
// bit_iter
//
// Purpose:
//   Walks the set bits of a captured W-bit vector one beat at a time. The
//   walk starts at a given position and goes round the vector circularly,
//   either ascending or descending. Each output beat carries the selected bit
//   as a one-hot vector and as a binary index. The final beat of each vector
//   is flagged. An all-zero vector yields a single "empty" beat.
//
// Parameters:
//   W          vector width; power of two, at least 2
//   P_DESCEND  0 = ascending circular scan, 1 = descending circular scan
//
// Optional feature:
//   BIT_ITER_CNT_EN  when defined, the population count of the vector is
//                    computed at accept time and held on cnt_o for all of
//                    that vector's beats. When undefined, cnt_o is tied to 0
//                    and no popcount logic exists.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   in_vld_i     input beat valid
//   in_rdy_o     input beat accepted when in_vld_i & in_rdy_o
//   in_x_i       vector to iterate
//   in_pos_i     start position (inclusive)
//   out_vld_o    output beat valid
//   out_rdy_i    output beat consumed when out_vld_o & out_rdy_i
//   out_y_o      one-hot selected bit
//   out_y_enc_o  binary index of out_y_o
//   out_last_o   final beat of the current vector
//   out_empty_o  captured vector was all-zero
//   cnt_o        population count of the captured vector
// ---------------------------------------------------------------------------
module bit_iter #(
  parameter int W         = 32,
  parameter int P_DESCEND = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld_i,
  output logic                 in_rdy_o,
  input  logic [W-1:0]         in_x_i,
  input  logic [$clog2(W)-1:0] in_pos_i,
  output logic                 out_vld_o,
  input  logic                 out_rdy_i,
  output logic [W-1:0]         out_y_o,
  output logic [$clog2(W)-1:0] out_y_enc_o,
  output logic                 out_last_o,
  output logic                 out_empty_o,
  output logic [$clog2(W):0]   cnt_o
);

  localparam int LW = $clog2(W);
  localparam int CW = LW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Bits of the current vector that have not been emitted yet, and the
  // position the next search starts from.
  logic [W-1:0]  res_q, res_d;
  logic [LW-1:0] ptr_q, ptr_d;

  // Registered output beat.
  logic          out_vld_q;
  logic [W-1:0]  out_y_q;
  logic [LW-1:0] out_enc_q;
  logic          out_last_q;
  logic          out_empty_q;

  logic accept;
  logic handshake;

  // Selection result for the next beat, computed from the next-state
  // residual and pointer so that it can be registered directly.
  logic [W-1:0]  masked;
  logic [LW-1:0] sel_enc;
  logic [W-1:0]  sel_y;
  logic          sel_last;
  logic          sel_empty;

  // Index of the lowest set bit of v (0 when v is zero).
  function automatic logic [LW-1:0] low_idx(input logic [W-1:0] v);
    logic [LW-1:0] idx;
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) idx = LW'(i);
    end
    return idx;
  endfunction

  // Index of the highest set bit of v (0 when v is zero).
  function automatic logic [LW-1:0] high_idx(input logic [W-1:0] v);
    logic [LW-1:0] idx;
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (v[i]) idx = LW'(i);
    end
    return idx;
  endfunction

  assign handshake = out_vld_q & out_rdy_i;

  // New vectors are taken while idle, or in the very cycle the last beat of
  // the current vector is consumed so consecutive vectors run with no gap.
  assign in_rdy_o = (state_q == IDLE) | (out_vld_q & out_last_q & out_rdy_i);
  assign accept   = in_vld_i & in_rdy_o;

  // Next-state logic. A consumed beat removes its bit from the residual and
  // moves the pointer one step past it (wrapping naturally since W is a
  // power of two). An accept overrides everything, because it can only
  // coincide with the final handshake of the previous vector.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    ptr_d   = ptr_q;
    if (handshake) begin
      res_d = res_q & ~out_y_q;
      if (P_DESCEND != 0) begin
        ptr_d = out_enc_q - LW'(1);
      end else begin
        ptr_d = out_enc_q + LW'(1);
      end
      if (out_last_q) begin
        state_d = IDLE;
      end
    end
    if (accept) begin
      res_d   = in_x_i;
      ptr_d   = in_pos_i;
      state_d = SCAN;
    end
  end

  // Circular search. First look only at the bits on the pointer's side of
  // the scan direction (pointer inclusive); if none remain there, wrap and
  // take the extreme bit of the whole residual.
  always_comb begin
    masked = '0;
    for (int i = 0; i < W; i++) begin
      if (P_DESCEND != 0) begin
        masked[i] = res_d[i] & (i <= int'(ptr_d));
      end else begin
        masked[i] = res_d[i] & (i >= int'(ptr_d));
      end
    end
    if (P_DESCEND != 0) begin
      sel_enc = (|masked) ? high_idx(masked) : high_idx(res_d);
    end else begin
      sel_enc = (|masked) ? low_idx(masked) : low_idx(res_d);
    end
    sel_empty = (res_d == '0);
    sel_y     = sel_empty ? '0 : (W'(1) << sel_enc);
    // Last when at most one bit remains; zero bits only happens for an
    // all-zero vector, whose single beat is also the last.
    sel_last  = ((res_d & (res_d - W'(1))) == '0);
  end

  // State, residual, pointer and output registers. The outputs are loaded
  // from the next-state selection, so they only move on a handshake or an
  // accept and therefore stay frozen while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      res_q       <= '0;
      ptr_q       <= '0;
      out_vld_q   <= 1'b0;
      out_y_q     <= '0;
      out_enc_q   <= '0;
      out_last_q  <= 1'b0;
      out_empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      ptr_q   <= ptr_d;
      if (state_d == SCAN) begin
        out_vld_q   <= 1'b1;
        out_y_q     <= sel_y;
        out_enc_q   <= sel_empty ? '0 : sel_enc;
        out_last_q  <= sel_last;
        out_empty_q <= sel_empty;
      end else begin
        out_vld_q   <= 1'b0;
        out_y_q     <= '0;
        out_enc_q   <= '0;
        out_last_q  <= 1'b0;
        out_empty_q <= 1'b0;
      end
    end
  end

  assign out_vld_o   = out_vld_q;
  assign out_y_o     = out_y_q;
  assign out_y_enc_o = out_enc_q;
  assign out_last_o  = out_last_q;
  assign out_empty_o = out_empty_q;

`ifdef BIT_ITER_CNT_EN
  logic [CW-1:0] cnt_q;

  function automatic logic [CW-1:0] popcount(input logic [W-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // The count is taken once at accept and held for every beat of the vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= popcount(in_x_i);
    end
  end

  assign cnt_o = cnt_q;
`else
  assign cnt_o = '0;
`endif

endmodule
